mat_sub_ctrl: RTL
=================

MAT_SUB_CTRL -- requirements
Module: mat_sub_ctrl

Interface
REQ-001 Parameter ROWS, default 5, number of matrix rows processed per operation.
REQ-002 Parameter LANES, default 5, signed elements per row.
REQ-003 Parameter EW, default 8, element width in bits; row width RW = LANES*EW (40 by default).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a matrix subtraction.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 rd_en  output  1  row read strobe to operand store.
REQ-009 rd_addr  output  clog2(ROWS)  row index being read.
REQ-010 rd_a, rd_b  input  RW each  operand rows; valid exactly one cycle after rd_en.
REQ-011 wr_en  output  1  result row valid.
REQ-012 wr_addr  output  clog2(ROWS)  destination row index.
REQ-013 wr_data  output  RW  result row A-B.
REQ-014 wr_ready  input  1  sink accepts the row when wr_en and wr_ready are both high.
REQ-015 ovf_mask  output  ROWS  bit r set if any lane of row r overflowed.
REQ-016 done  output  1  one-cycle pulse at end of operation.

Function
REQ-017 The FSM SHALL have states IDLE, READ, EXEC, WRITE, DONE.
REQ-018 In IDLE, start=1 SHALL clear ovf_mask and the row counter, and the FSM SHALL enter READ.
REQ-019 In READ, the block SHALL assert rd_en=1 with rd_addr=row, then enter EXEC.
REQ-020 In EXEC, the block SHALL register the rd_a/rd_b lane differences and the row overflow, then enter WRITE.
REQ-021 In WRITE, the block SHALL hold wr_en=1, wr_addr=row and wr_data stable until wr_ready=1.
REQ-022 On a WRITE handshake, the block SHALL OR the row overflow into ovf_mask[row].
REQ-023 On a WRITE handshake, if row==ROWS-1 the FSM SHALL enter DONE; otherwise it SHALL increment row and enter READ.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then the FSM SHALL enter IDLE; ovf_mask SHALL hold until the next accepted start.
REQ-025 With wr_ready tied high, done SHALL occur 3*ROWS+1 cycles after the start-sampling edge (16 for ROWS=5).
REQ-026 Each lane SHALL compute a signed EW+1-bit difference a_i-b_i; lane overflow is set when bit EW differs from bit EW-1.
REQ-027 Lane i SHALL occupy bits [EW*i+EW-1 : EW*i] in rd_a, rd_b and wr_data.
REQ-028 start while busy SHALL be ignored; start in DONE SHALL be ignored.
REQ-029 rd_en and wr_en SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=0 at any clock edge SHALL force IDLE and clear row, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data, ovf_mask and done.
REQ-031 Reset mid-operation SHALL abort the operation with no further write or done pulse.

Configuration
REQ-032 With SUB_SAT_EN defined, an overflowing lane SHALL saturate to +2^(EW-1)-1 or -2^(EW-1), according to the sign of the EW+1-bit result.
REQ-033 Without SUB_SAT_EN, an overflowing lane SHALL wrap, keeping the low EW bits.
REQ-034 ovf_mask reporting SHALL be identical with and without SUB_SAT_EN.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the default LANES/EW/ROWS constants, and the saturation limit constants.
REQ-036 Lane arithmetic SHALL live in one combinational sub-module, row_sub_lanes, producing RW result bits plus LANES overflow bits; mat_sub_ctrl SHALL own all registers.

Verification
REQ-037 Test: all rows A=0x0A…, B=0x03… with wr_ready=1 -> every lane 0x07, ovf_mask=0, done 16 cycles after start.
REQ-038 Test: row 2 lane 0 computes 0x7F-0xFF (127-(-1)) -> ovf_mask=5'b00100; lane = 0x80 without SUB_SAT_EN, 0x7F with it.
REQ-039 Test: row 4 lane 3 computes 0x80-0x01 -> ovf_mask[4]=1; lane = 0x7F wrapped, 0x80 saturated.
REQ-040 Test: wr_ready low for 4 cycles on row 1 -> wr_data/wr_addr held stable, no rd_en in that window, done delayed exactly 4 cycles.
REQ-041 Test: rst=0 during EXEC of row 3 -> next cycle IDLE with all outputs 0 and no done; a new start then completes normally.
REQ-042 Test: start pulsed again while busy -> ignored, exactly one done and 5 writes.

Source files
------------

// File: rtl/mat_sub_ctrl_pkg.sv
// Shared types and constants for the matrix-subtract controller.
// Saturation limits apply when the design is built with SUB_SAT_EN.
package mat_sub_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DEF_ROWS  = 5;
  localparam int DEF_LANES = 5;
  localparam int DEF_EW    = 8;

  localparam int SAT_HI = (1 << (DEF_EW - 1)) - 1;
  localparam int SAT_LO = -(1 << (DEF_EW - 1));

  // Saturation limits for an arbitrary element width.
  function automatic int sat_hi(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int ew);
    return -(1 << (ew - 1));
  endfunction

endpackage

// File: rtl/mat_sub_ctrl_row_sub_lanes.sv
// Combinational per-lane signed subtraction a-b with overflow flags.
// SUB_SAT_EN selects saturation of overflowing lanes; otherwise they wrap.
module row_sub_lanes
  import mat_sub_ctrl_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW
) (
  input  logic [LANES*EW-1:0] a,
  input  logic [LANES*EW-1:0] b,
  output logic [LANES*EW-1:0] res,
  output logic [LANES-1:0]    ovf
);

  function automatic logic [EW-1:0] fit(input logic signed [EW:0] d);
`ifdef SUB_SAT_EN
    if (d[EW] != d[EW-1]) return d[EW] ? EW'(sat_lo(EW)) : EW'(sat_hi(EW));
`endif
    return d[EW-1:0];
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [EW-1:0] ea;
    logic signed [EW-1:0] eb;
    logic signed [EW:0]   d;

    assign ea = a[EW*i +: EW];
    assign eb = b[EW*i +: EW];
    // One guard bit makes the difference exact; overflow is a guard/sign disagreement.
    assign d  = $signed({ea[EW-1], ea}) - $signed({eb[EW-1], eb});
    assign ovf[i] = d[EW] ^ d[EW-1];
    assign res[EW*i +: EW] = fit(d);
  end

endmodule

// File: rtl/mat_sub_ctrl.sv
// Row-sequential matrix subtraction controller: read A/B row, subtract, write A-B.
// Build option SUB_SAT_EN (in row_sub_lanes) saturates overflowing lanes.
module mat_sub_ctrl
  import mat_sub_ctrl_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW,
  localparam int RW   = LANES * EW,
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [RW-1:0] rd_a,
  input  logic [RW-1:0] rd_b,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [RW-1:0] wr_data,
  input  logic          wr_ready,
  output logic [ROWS-1:0] ovf_mask,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

  state_t          state, state_nx;
  logic [AW-1:0]   row;
  logic [RW-1:0]   lane_res;
  logic [LANES-1:0] lane_ovf;
  logic [RW-1:0]   res_p1;
  logic            rovf_p1;

  row_sub_lanes #(
    .LANES(LANES),
    .EW   (EW)
  ) u_lanes (
    .a  (rd_a),
    .b  (rd_b),
    .res(lane_res),
    .ovf(lane_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      row      <= '0;
      res_p1   <= '0;
      rovf_p1  <= 1'b0;
      ovf_mask <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          row      <= '0;
          ovf_mask <= '0;
        end
        // Stage p1: operands arrive one cycle after rd_en, result is captured here.
        S_EXEC: begin
          res_p1  <= lane_res;
          rovf_p1 <= |lane_ovf;
        end
        S_WRITE: if (wr_ready) begin
          ovf_mask[row] <= ovf_mask[row] | rovf_p1;
          if (row != LAST) row <= row + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_READ;
      end
      S_READ: begin
        rd_en    = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC:  state_nx = S_WRITE;
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) state_nx = (row == LAST) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign rd_addr = row;
  assign wr_addr = row;
  assign wr_data = res_p1;

endmodule
